// File: rtl/eprisc_iobus_master.sv
// rtl/eprisc_iobus_master.sv - epRISC I/O bus host master: serialises 32-bit requests into six-phase byte frames
module eprisc_iobus_master #(
    parameter int         pClkDiv = 2,
    parameter logic [1:0] pTarget = 2'h1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [14:0] iReqAddr,
    input  logic [15:0] iReqData,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt,
    output logic        oIrq
);

    localparam int cCntW = (pClkDiv < 1) ? 1 : $clog2(pClkDiv + 1);
    localparam logic [cCntW-1:0] cHalfLast  = cCntW'(pClkDiv - 1);
    localparam logic [cCntW-1:0] cFlushLast = cCntW'(pClkDiv);

    typedef enum logic [3:0] {
        sFlushLo, sFlushHi, sIdle, sLeadLo, sByteHi,
        sByteLo, sStoreHi, sStoreLo, sEndHi, sDone
    } tState;

    tState             state, nextState;
    logic [cCntW-1:0]  cnt, nextCnt;
    logic [1:0]        byteIdx, nextByte;
    logic [31:0]       frameWord, frameWordNxt;
    logic              accept, timed, halfDone;
    logic              busClockNxt, reqReadyNxt, rspValidNxt;
    logic [1:0]        busSelectNxt;
    logic [7:0]        mosiNxt;
    logic [31:0]       rspDataNxt;
    logic              irqMeta;

    assign accept = iReqValid && oReqReady;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state      <= sFlushLo;
            cnt        <= '0;
            byteIdx    <= '0;
            frameWord  <= '0;
            oBusClock  <= 1'b1;
            oBusSelect <= '0;
            oBusMOSI   <= '0;
            oReqReady  <= 1'b0;
            oRspValid  <= 1'b0;
            oRspData   <= '0;
        end else begin
            state      <= nextState;
            cnt        <= nextCnt;
            byteIdx    <= nextByte;
            frameWord  <= frameWordNxt;
            oBusClock  <= busClockNxt;
            oBusSelect <= busSelectNxt;
            oBusMOSI   <= mosiNxt;
            oReqReady  <= reqReadyNxt;
            oRspValid  <= rspValidNxt;
            oRspData   <= rspDataNxt;
        end
    end

    // The first FLUSH_LO cycle still shows the reset-time high clock, so the
    // low half there runs one cycle longer to give pClkDiv visible low cycles.
    always_comb begin
        nextState    = state;
        nextCnt      = cnt;
        nextByte     = byteIdx;
        frameWordNxt = frameWord;
        timed        = !(state inside {sIdle, sDone});
        halfDone     = (cnt == ((state == sFlushLo) ? cFlushLast : cHalfLast));
        if (timed) begin
            if (halfDone) begin
                nextCnt = '0;
                case (state)
                    sFlushLo: nextState = sFlushHi;
                    sFlushHi: nextState = sIdle;
                    sLeadLo:  nextState = sByteHi;
                    sByteHi:  nextState = sByteLo;
                    sByteLo: begin
                        if (byteIdx == 2'd3) begin
                            nextState = sStoreHi;
                        end else begin
                            nextState = sByteHi;
                            nextByte  = byteIdx + 2'd1;
                        end
                    end
                    sStoreHi: nextState = sStoreLo;
                    sStoreLo: nextState = sEndHi;
                    sEndHi:   nextState = sDone;
                    default:  nextState = sFlushLo;
                endcase
            end else begin
                nextCnt = cnt + 1'b1;
            end
        end else if (state == sDone) begin
            nextState = sIdle;
        end else if (accept) begin
            nextState    = sLeadLo;
            nextCnt      = '0;
            nextByte     = '0;
            frameWordNxt = {iReqWrite, iReqAddr, iReqData};
        end
    end

    // Outputs are registered from the state being entered, so bus pins move
    // on the same edge as the state they belong to.
    always_comb begin
        busClockNxt  = nextState inside {sFlushHi, sIdle, sByteHi, sStoreHi, sEndHi, sDone};
        busSelectNxt = (nextState inside {sLeadLo, sByteHi, sByteLo, sStoreHi, sStoreLo, sEndHi})
                       ? pTarget : 2'b00;
        reqReadyNxt  = (nextState == sIdle);
        rspValidNxt  = (nextState == sDone);
        mosiNxt      = oBusMOSI;
        rspDataNxt   = oRspData;
        if (nextState == sByteHi && state != sByteHi) begin
            mosiNxt = frameWord[{nextByte, 3'b000} +: 8];
        end else if (nextState == sStoreHi && state != sStoreHi) begin
            mosiNxt = 8'h00;
        end
        if (state == sByteHi && nextState == sByteLo) begin
            rspDataNxt[{byteIdx, 3'b000} +: 8] = iBusMISO;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            irqMeta <= 1'b0;
            oIrq    <= 1'b0;
        end else begin
            irqMeta <= iBusInterrupt;
            oIrq    <= irqMeta;
        end
    end

endmodule

// File: tb/tb_eprisc_iobus_master.sv
// tb/tb_eprisc_iobus_master.sv - scoreboard bench for eprisc_iobus_master with a simple controller model
module tb_eprisc_iobus_master;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iReqValid = 1'b0;
    logic        oReqReady;
    logic        iReqWrite = 1'b0;
    logic [14:0] iReqAddr = '0;
    logic [15:0] iReqData = '0;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO = '0;
    logic        iBusInterrupt = 1'b0;
    logic        oIrq;

    eprisc_iobus_master #(.pClkDiv(2), .pTarget(2'h1)) dut (
        .iClk(iClk), .iRst(iRst),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWrite(iReqWrite),
        .iReqAddr(iReqAddr), .iReqData(iReqData),
        .oRspValid(oRspValid), .oRspData(oRspData),
        .oBusClock(oBusClock), .oBusSelect(oBusSelect), .oBusMOSI(oBusMOSI),
        .iBusMISO(iBusMISO), .iBusInterrupt(iBusInterrupt), .oIrq(oIrq)
    );

    always #5 iClk = ~iClk;

    typedef struct { logic [31:0] w; logic [31:0] miso; } tFrame;
    typedef struct { logic [31:0] data; int acc; } tRsp;

    tFrame frameQ[$];
    tRsp   rspQ[$];
    logic [15:0] tbRam [logic [14:0]];
    logic [14:0] prevAddr = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int edgeCnt = 0;
    int rspCnt = 0;
    int mosiGlitches = 0;
    logic [31:0] lastRsp = '0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Controller side: watches the bus, checks MOSI bytes and drives MISO.
    initial begin
        logic       prevClk;
        logic [1:0] prevSel;
        logic [7:0] prevMosi;
        tFrame      cur;
        tRsp        r;
        prevClk  = 1'b1;
        prevSel  = '0;
        prevMosi = '0;
        cur      = '{32'h0, 32'h0};
        forever begin
            @(negedge iClk);
            if (iRst) begin
                edgeCnt = 0;
            end else begin
                if (oBusMOSI != prevMosi && !(oBusClock && !prevClk)) mosiGlitches++;
                if (oBusSelect != 2'b00 && prevSel == 2'b00) begin
                    edgeCnt = 0;
                    checkVal("frameSel", 32'(oBusSelect), 32'h1);
                    if (frameQ.size() == 0) begin
                        checkVal("frameUnexpected", 32'h1, 32'h0);
                        cur = '{32'h0, 32'h0};
                    end else begin
                        cur = frameQ.pop_front();
                    end
                end
                if (oBusSelect != 2'b00 && oBusClock && !prevClk) begin
                    edgeCnt++;
                    if (edgeCnt <= 4) begin
                        checkVal("mosiByte", 32'(oBusMOSI), 32'(cur.w[8*(edgeCnt-1) +: 8]));
                        iBusMISO = cur.miso[8*(edgeCnt-1) +: 8];
                    end else if (edgeCnt == 5) begin
                        checkVal("mosiStore", 32'(oBusMOSI), 32'h0);
                    end
                end
                if (oRspValid) begin
                    rspCnt++;
                    lastRsp = oRspData;
                    checkVal("rspEdges", 32'(edgeCnt), 32'd6);
                    if (rspQ.size() == 0) begin
                        checkVal("rspUnexpected", 32'h1, 32'h0);
                    end else begin
                        r = rspQ.pop_front();
                        checkVal("rspData", oRspData, r.data);
                        checkVal("rspLatency", 32'(cyc - r.acc), 32'd25);
                    end
                end
            end
            prevClk  = oBusClock;
            prevSel  = oBusSelect;
            prevMosi = oBusMOSI;
        end
    end

    function automatic logic [15:0] ramRead(input logic [14:0] a);
        return tbRam.exists(a) ? tbRam[a] : 16'h0;
    endfunction

    task automatic sendReq(input logic w, input logic [14:0] a, input logic [15:0] d,
                           input logic useOvr, input logic [31:0] ovr, input logic keep,
                           output int acc);
        logic [31:0] miso;
        int n;
        miso = useOvr ? ovr : {16'h0, ramRead(prevAddr)};
        if (w) tbRam[a] = d;
        prevAddr = a;
        @(negedge iClk);
        iReqValid = 1'b1;
        iReqWrite = w;
        iReqAddr  = a;
        iReqData  = d;
        n = 0;
        while (!oReqReady && n < 200) begin
            @(negedge iClk);
            n++;
        end
        if (!oReqReady) begin
            checkVal("acceptTimeout", 32'h0, 32'h1);
            iReqValid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        frameQ.push_back('{{w, a, d}, miso});
        rspQ.push_back('{miso, acc});
        @(posedge iClk);
        #1;
        if (!keep) iReqValid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (rspQ.size() != 0 && n < 300) begin
            @(negedge iClk);
            n++;
        end
        if (rspQ.size() != 0) checkVal("drainTimeout", 32'(rspQ.size()), 32'h0);
        @(negedge iClk);
    endtask

    task automatic releaseAndCheckFlush();
        @(negedge iClk);
        #2;
        iRst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge iClk);
            if (i <= 4) checkVal("flushClk", 32'(oBusClock), (i >= 3) ? 32'h1 : 32'h0);
            checkVal("flushSel", 32'(oBusSelect), 32'h0);
            checkVal("flushReady", 32'(oReqReady), (i == 5) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int accs[4];
        int n;
        int snap;

        repeat (3) @(negedge iClk);
        checkVal("rstClk",      32'(oBusClock),  32'h1);
        checkVal("rstSel",      32'(oBusSelect), 32'h0);
        checkVal("rstMosi",     32'(oBusMOSI),   32'h0);
        checkVal("rstReady",    32'(oReqReady),  32'h0);
        checkVal("rstRspValid", 32'(oRspValid),  32'h0);
        checkVal("rstRspData",  oRspData,        32'h0);
        checkVal("rstIrq",      32'(oIrq),       32'h0);
        releaseAndCheckFlush();

        sendReq(1'b1, 15'h0102, 16'hBEEF, 1'b1, 32'h44332211, 1'b0, acc);
        waitDrain();
        checkVal("firstRsp", lastRsp, 32'h44332211);

        sendReq(1'b1, 15'h0300, 16'hCAFE, 1'b0, 32'h0, 1'b0, acc);
        waitDrain();
        sendReq(1'b0, 15'h0300, 16'h1234, 1'b0, 32'h0, 1'b0, acc);
        waitDrain();
        sendReq(1'b0, 15'h0300, 16'h5678, 1'b0, 32'h0, 1'b0, acc);
        waitDrain();
        checkVal("readPair", lastRsp, 32'h0000CAFE);

        for (int i = 0; i < 4; i++)
            sendReq(1'(i), 15'($urandom), 16'($urandom), 1'b1, $urandom, 1'b1, accs[i]);
        iReqValid = 1'b0;
        waitDrain();
        for (int i = 1; i < 4; i++)
            checkVal("b2bSpacing", 32'(accs[i] - accs[i-1]), 32'd26);

        sendReq(1'b1, 15'h0055, 16'hA5A5, 1'b1, 32'h0BADF00D, 1'b0, acc);
        n = 0;
        do begin
            @(negedge iClk);
            #1;
            n++;
        end while (edgeCnt != 3 && n < 100);
        checkVal("reachByte2", 32'(edgeCnt), 32'd3);
        iRst = 1'b1;
        #1;
        checkVal("midRstClk",   32'(oBusClock),  32'h1);
        checkVal("midRstSel",   32'(oBusSelect), 32'h0);
        checkVal("midRstMosi",  32'(oBusMOSI),   32'h0);
        checkVal("midRstReady", 32'(oReqReady),  32'h0);
        frameQ.delete();
        rspQ.delete();
        snap = rspCnt;
        repeat (2) @(negedge iClk);
        releaseAndCheckFlush();
        repeat (30) @(negedge iClk);
        checkVal("noRspAfterRst", 32'(rspCnt - snap), 32'h0);

        sendReq(1'b0, 15'h7FFF, 16'h0001, 1'b1, 32'hDEADBEEF, 1'b0, acc);
        waitDrain();
        checkVal("recoverRsp", lastRsp, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) begin
            @(negedge iClk);
            checkVal("irqSync", 32'(oIrq), (i >= 2 && i <= 4) ? 32'h1 : 32'h0);
            if (i == 0) iBusInterrupt = 1'b1;
            if (i == 3) iBusInterrupt = 1'b0;
        end

        checkVal("mosiGlitches", 32'(mosiGlitches), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eprisc_iobus_master.md
# eprisc_iobus_master

Host-side master for the epRISC 8-bit I/O bus. It accepts 32-bit I/O requests (write flag, 15-bit address, 16-bit data) from the CPU side and serialises each one into a six-phase byte frame on the I/O bus. It captures the four MISO bytes returned by the I/O controller and synchronises the controller's interrupt line into the host clock domain. It sits directly upstream of the I/O controller and drives its iBusClock/iBusSelect/iBusMOSI inputs.

## Interface
- pClkDiv, 2, iClk cycles per bus-clock half period (≥1)
- pTarget, 2'h1, value driven on oBusSelect during a frame (≠0)
- iClk  in  1  system clock; all logic on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iReqValid  in  1  request present
- oReqReady  out  1  master can accept request this cycle
- iReqWrite  in  1  1 = write frame, 0 = read frame
- iReqAddr  in  15  peripheral address
- iReqData  in  16  write data (ignored for reads, still transmitted)
- oRspValid  out  1  one-cycle pulse: frame complete, oRspData valid
- oRspData  out  32  MISO bytes {b3,b2,b1,b0}
- oBusClock  out  1  I/O bus clock
- oBusSelect  out  2  I/O bus select, 0 = deselected
- oBusMOSI  out  8  I/O bus data to controller
- iBusMISO  in  8  I/O bus data from controller
- iBusInterrupt  in  1  controller interrupt, asynchronous
- oIrq  out  1  iBusInterrupt after 2-flop synchroniser

## Operation
- Frame word W = {iReqWrite, iReqAddr, iReqData}; bytes sent LSB first: b0=W[7:0], b1=W[15:8], b2=W[23:16], b3=W[31:24].
- Accept when iReqValid && oReqReady; W latched that edge; oReqReady drops next cycle.
- States: FLUSH_LO, FLUSH_HI, IDLE, LEAD_LO, BYTE_HI(k=0..3), BYTE_LO(k=0..3), STORE_HI, STORE_LO, END_HI, DONE.
- Reset values (async): oBusClock=1, oBusSelect=0, oBusMOSI=0, oReqReady=0, oRspValid=0, oRspData=0, oIrq=0, state FLUSH_LO.
- FLUSH: after reset release, oBusClock low pClkDiv cycles then high pClkDiv cycles with oBusSelect=0; this rising edge forces the controller pipeline to its load phase (and pulses peripheral reset). Then IDLE.
- IDLE: oBusClock=1, oBusSelect=0, oReqReady=1. oBusClock never low while deselected outside FLUSH (low+deselected resets peripherals).
- On accept: oBusSelect=pTarget, enter LEAD_LO (clock low). Sequence of halves: LEAD_LO, BYTE_HI0, BYTE_LO0, …, BYTE_HI3, BYTE_LO3, STORE_HI, STORE_LO, END_HI; each half lasts pClkDiv cycles.
- Entering BYTE_HIk (clock rising): oBusMOSI ← bk, held through BYTE_LOk.
- Entering BYTE_LOk (clock falling): sample iBusMISO into oRspData byte k.
- STORE_HI/STORE_LO: oBusMOSI=0; END_HI rising edge is the controller's store edge (write commits).
- After END_HI: DONE for one cycle: oRspValid=1, oBusSelect=0, clock stays high, then IDLE.
- Reads: controller returns data for the address latched in the preceding frame; host issues read frames in pairs with identical address; second response is the read data. Master adds no semantics.
- oIrq: two-flop synchroniser, independent of frame state.

## Timing
- Frame = 6 rising + 6 falling bus-clock edges; accept-to-oRspValid = 12·pClkDiv + 1 cycles; default 25.
- Back-to-back: next accept earliest the cycle after oRspValid; minimum request spacing 12·pClkDiv + 2.
- oBusMOSI changes only on oBusClock rising edges; MISO sampled only on falling edges.
- iReqValid ignored when oReqReady=0; no queuing.
- Reset mid-frame: outputs return to reset values immediately, frame discarded, no oRspValid, FLUSH repeats.
- oIrq latency 2–3 cycles from iBusInterrupt edge.
- Half-period counter wraps at pClkDiv−1; byte index 0..3, no wrap beyond 3.

## Test plan
- Reset release, pClkDiv=2 -> oBusClock low 2 cycles, high 2, oBusSelect=0 throughout, then oReqReady=1.
- Write addr 15'h0102, data 16'hBEEF -> MOSI bytes EF,BE,02,81 on rising edges 1–4, oBusSelect=1, oRspValid at accept+25.
- Controller model returning 11,22,33,44 on MISO -> oRspData=32'h44332211.
- Two reads of addr 15'h0300 with model RAM word 0x0000CAFE -> second oRspData=32'h0000CAFE.
- iRst asserted during BYTE_HI2 -> oBusClock=1, oBusSelect=0 same cycle, no oRspValid, flush sequence follows.
- iReqValid held high continuously -> accepts spaced exactly 26 cycles; iBusInterrupt pulse of 3 cycles -> oIrq high 3 cycles, delayed 2.
